// File: rtl/ltc231x_pkg.sv
// Shared types and timing helpers for the multi-channel LTC231x reader.
package ltc231x_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCnv,
        StWait,
        StShift,
        StDone,
        StHold
    } state_e;

    // Cycles from the cycle read is sampled in IDLE to the data_valid cycle.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned sck_div,
                                              input int unsigned cnv_cyc,
                                              input int unsigned conv_cyc);
        return cnv_cyc + conv_cyc + 2 * sck_div * data_w + 1;
    endfunction

endpackage

// File: rtl/ltc231x_multi_reader_lane.sv
// One ADC lane: MSB-first serial-in shift register, advanced on capture enable.
module adc_shift_lane #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_en_i,
    input  logic              sdo_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en_i) begin
            data_d = {data_q[DATA_W-2:0], sdo_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ltc231x_multi_reader.sv
// Drives shared cnv_n/sck to N_CH LTC231x ADCs and deserialises one SDO line per ADC,
// in single-shot or fixed-period free-running mode.
module ltc231x_multi_reader
    import ltc231x_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned N_CH          = 2,
    parameter int unsigned SCK_DIV       = 2,
    parameter int unsigned CNV_CYC       = 2,
    parameter int unsigned CONV_CYC      = 8,
    parameter int unsigned SAMPLE_PERIOD = 100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     read,
    input  logic                     continuous,
    input  logic [N_CH-1:0]          sdo,
    output logic                     cnv_n,
    output logic                     sck,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic                     data_valid,
    output logic                     busy
);

    localparam int unsigned LMin  = frame_len(DATA_W, SCK_DIV, CNV_CYC, CONV_CYC);
    localparam int unsigned PhMax =
        (CNV_CYC > CONV_CYC) ? ((CNV_CYC > SCK_DIV) ? CNV_CYC : SCK_DIV)
                             : ((CONV_CYC > SCK_DIV) ? CONV_CYC : SCK_DIV);
    localparam int unsigned PhW   = $clog2(PhMax) + 1;
    localparam int unsigned BitW  = $clog2(DATA_W) + 1;
    localparam int unsigned PerW  = $clog2(SAMPLE_PERIOD) + 1;

    if (SAMPLE_PERIOD < LMin) begin : g_bad_period
        $error("SAMPLE_PERIOD is shorter than one complete frame");
    end

    state_e                   state_q, state_d;
    logic [PhW-1:0]           phase_q, phase_d;
    logic [BitW-1:0]          bit_q, bit_d;
    logic [PerW-1:0]          per_q, per_d;
    logic                     cont_q, cont_d;
    logic                     sck_q, sck_d;
    logic                     cnv_n_q, busy_q, valid_q;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic [N_CH*DATA_W-1:0]   lanes;
    logic                     shift_en;
    logic                     period_done;

    assign period_done = (per_q == PerW'(SAMPLE_PERIOD - 1));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        cont_d   = cont_q;
        sck_d    = 1'b0;
        shift_en = 1'b0;
        per_d    = (state_q == StIdle) ? per_q : per_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (read) begin
                    cont_d  = continuous;
                    state_d = StCnv;
                end
            end
            StCnv: begin
                if (phase_q == PhW'(CNV_CYC - 1)) begin
                    phase_d = '0;
                    state_d = StWait;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StWait: begin
                if (phase_q == PhW'(CONV_CYC - 1)) begin
                    phase_d = '0;
                    state_d = StShift;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StShift: begin
                if (phase_q == PhW'(SCK_DIV - 1)) begin
                    phase_d = '0;
                    if (!sck_q) begin
                        // Capture on the edge that raises sck: ADC data settled since the fall.
                        sck_d    = 1'b1;
                        shift_en = 1'b1;
                    end else if (bit_q == BitW'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = StDone;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    sck_d   = sck_q;
                end
            end
            StDone: begin
                if (!cont_q) begin
                    state_d = StIdle;
                end else if (period_done) begin
                    // Minimum period: the next conversion starts straight after DONE.
                    if (read) begin
                        cont_d  = continuous;
                        state_d = StCnv;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (period_done) begin
                    if (read) begin
                        cont_d  = continuous;
                        state_d = StCnv;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Period is measured from each cnv_n falling edge.
        if (state_d == StCnv && state_q != StCnv) begin
            per_d = '0;
        end

        data_d = (state_d == StDone) ? lanes : data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            cont_q  <= 1'b0;
            sck_q   <= 1'b0;
            cnv_n_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            cont_q  <= cont_d;
            sck_q   <= sck_d;
            cnv_n_q <= (state_d != StCnv);
            busy_q  <= (state_d != StIdle);
            valid_q <= (state_d == StDone);
            data_q  <= data_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        adc_shift_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk_i     (clk),
            .rst_ni    (reset_n),
            .shift_en_i(shift_en),
            .sdo_i     (sdo[c]),
            .data_o    (lanes[c*DATA_W +: DATA_W])
        );
    end

    assign cnv_n      = cnv_n_q;
    assign sck        = sck_q;
    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign data_out   = data_q;

endmodule

// File: doc/ltc231x_multi_reader.md
# ltc231x_multi_reader

Parametrised successor to the single-channel LTC2311 reader. It drives a shared active-low conversion strobe and SPI clock to N_CH simultaneously sampled LTC231x-family ADCs. It deserialises one SDO line per ADC into a packed word and emits one-cycle data_valid pulses. Adds single-shot and free-running modes with a programmable sample period. It sits between the ADC pins and the sample-processing datapath.

## Interface
- DATA_W, 16: bits per conversion (12..18).
- N_CH, 2: number of ADCs sharing cnv_n and sck (1..8).
- SCK_DIV, 2: sck half-period in clk cycles (≥1).
- CNV_CYC, 2: cycles cnv_n is held low (≥1).
- CONV_CYC, 8: wait cycles after cnv_n release before the first sck (≥1).
- SAMPLE_PERIOD, 100: cycles between cnv_n falling edges in continuous mode. Must be ≥ L_MIN = CNV_CYC+CONV_CYC+2·SCK_DIV·DATA_W+1, otherwise elaboration error.
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- read  in  1  level request: start frame (single) / keep running (continuous).
- continuous  in  1  0 = single-shot, 1 = free-running; sampled only in IDLE/HOLD at frame start.
- sdo  in  N_CH  serial data, one bit per ADC; ADC updates on sck falling.
- cnv_n  out  1  conversion strobe, active low.
- sck  out  1  SPI clock, idles low.
- data_out  out  N_CH·DATA_W  channel c in bits [c·DATA_W +: DATA_W], MSB first.
- data_valid  out  1  one-cycle pulse; data_out updated in the same cycle.
- busy  out  1  frame or continuous run in progress.

## Operation
- States: IDLE, CNV, WAIT, SHIFT, DONE, HOLD.
- IDLE: when read=1, latch continuous and go to CNV.
- CNV: cnv_n=0 for CNV_CYC cycles, then go to WAIT.
- WAIT: cnv_n=1 for CONV_CYC cycles, then go to SHIFT.
- SHIFT: DATA_W sck periods; each is SCK_DIV cycles low then SCK_DIV cycles high.
  - sdo[c] is captured into lane c on the clk edge that drives sck 0→1. First capture = MSB.
  - No capture on sck falling.
- DONE: one cycle. data_out ← all lanes, data_valid=1.
  - Single mode: go to IDLE.
  - Continuous mode: go to HOLD.
- HOLD: counts to SAMPLE_PERIOD measured from the previous cnv_n fall.
  - At expiry: if read=1, re-latch continuous and go to CNV. Otherwise go to IDLE.
- read is ignored outside IDLE/HOLD. Dropping read mid-frame completes the current frame.
- The shift lanes are not cleared between frames. data_out holds its value until the next DONE.
- Reset (sampled at a clk edge, any state): next state IDLE; all counters zeroed; cnv_n=1, sck=0, data_valid=0, busy=0, data_out=0. A partial frame is discarded and no data_valid is produced.

## Timing
- Cycle 0: read=1 sampled in IDLE.
- cnv_n low in cycles 1..CNV_CYC.
- First sck rise at cycle 1+CNV_CYC+CONV_CYC+SCK_DIV.
- data_valid at cycle L = CNV_CYC+CONV_CYC+2·SCK_DIV·DATA_W+1. Default config: L = 75.
- busy: high from cycle 1 through the data_valid cycle.
  - Single mode: low the following cycle.
  - Continuous mode: stays high through HOLD until return to IDLE.
- Continuous mode: cnv_n falls exactly every SAMPLE_PERIOD cycles. Jitter is 0.
- All outputs are registered; no combinational path from input to output.
- Counter widths are $clog2 of their maximum value +1. No counter wraps within a frame.

## Structure
- ltc231x_pkg holds:
  - the state enum,
  - the function frame_len(DATA_W, SCK_DIV, CNV_CYC, CONV_CYC) used for the L_MIN check and by the bench.
- Sub-module adc_shift_lane (DATA_W-bit MSB-first shift register with capture enable), generated N_CH times.
- The top contains the FSM, the sck/phase counter, the bit counter and the period counter.

## Test plan
All scenarios use the default parameters.
- Single shot: read=1 for one cycle; sdo[0] streams 0xDEAD, sdo[1] streams 0xC0DE → one data_valid at cycle 75, data_out=0xC0DE_DEAD, busy low at cycle 76, exactly 16 sck rises.
- Continuous: read held, continuous=1 → cnv_n falls at cycles 1, 101, 201; data_valid at 75, 175, 275. Per-frame patterns 0x1234/0xABCD are reproduced in order.
- Stop: drop read at cycle 40 of frame 2 → frame 2 completes with data_valid; no further cnv_n fall; busy low after the HOLD expiry.
- Reset mid-SHIFT (cycle 30): next cycle cnv_n=1, sck=0, busy=0, data_out=0; no data_valid. A new read yields a correct frame at +75.
- Ignored request: pulse read at cycle 20 during single-shot → no second frame; exactly one data_valid.
- Edge data: both channels all-ones then all-zeros → 0xFFFF_FFFF then 0x0000_0000. Checks MSB/LSB framing and lane packing.
